// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: checks the ID-time prediction against the actual
// outcome and issues a one-cycle corrective redirect plus front-end flush.
module branch_resolve_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic        id_branchBType,
  input  logic        id_branchJAL,
  input  logic        id_branchJALR,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_offset,
  input  logic        id_pred_taken,
  input  logic [31:0] id_pred_pc,
  input  logic        stall_ex,
  input  logic        ex_cond_true,
  input  logic [31:0] ex_rs1,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush_front,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_B    = 2'd1,
    BR_JAL  = 2'd2,
    BR_JALR = 2'd3
  } br_type_e;

  typedef enum logic {
    IDLE    = 1'b0,
    RECOVER = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic            ent_valid_q, ent_valid_d;
  br_type_e        ent_type_q, ent_type_d;
  logic [XLEN-1:0] ent_pc_q, ent_pc_d;
  logic [XLEN-1:0] ent_off_q, ent_off_d;
  logic            ent_pred_taken_q, ent_pred_taken_d;
  logic [XLEN-1:0] ent_pred_pc_q, ent_pred_pc_d;

  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            flush_front_q, flush_front_d;
  logic [XLEN-1:0] branch_cnt_q, branch_cnt_d;
  logic [XLEN-1:0] mispred_cnt_q, mispred_cnt_d;

  br_type_e        id_type_c;
  logic            resolve_c;
  logic            act_taken_c;
  logic [XLEN-1:0] target_c;
  logic [XLEN-1:0] correct_pc_c;
  logic            mispredict_c;

  // Decode the ID branch class into a compact entry type
  always_comb begin
    id_type_c = BR_NONE;
    if (id_branchJALR)       id_type_c = BR_JALR;
    else if (id_branchJAL)   id_type_c = BR_JAL;
    else if (id_branchBType) id_type_c = BR_B;
  end

  // Actual outcome of the entry currently in EX
  always_comb begin
    resolve_c    = ent_valid_q && !stall_ex && (ent_type_q != BR_NONE) && (state_q == IDLE);
    act_taken_c  = 1'b0;
    target_c     = ent_pc_q + ent_off_q;
    case (ent_type_q)
      BR_B:    act_taken_c = ex_cond_true;
      BR_JAL:  act_taken_c = 1'b1;
      BR_JALR: begin
        act_taken_c = 1'b1;
        target_c    = (ex_rs1 + ent_off_q) & ~XLEN'(1);
      end
      default: act_taken_c = 1'b0;
    endcase
    correct_pc_c = act_taken_c ? target_c : ent_pc_q + XLEN'(4);
    mispredict_c = resolve_c &&
                   ((act_taken_c != ent_pred_taken_q) ||
                    (act_taken_c && ent_pred_taken_q && (target_c != ent_pred_pc_q)));
  end

  // Next-state for the entry, FSM, outputs and counters
  always_comb begin
    state_d          = state_q;
    ent_valid_d      = ent_valid_q;
    ent_type_d       = ent_type_q;
    ent_pc_d         = ent_pc_q;
    ent_off_d        = ent_off_q;
    ent_pred_taken_d = ent_pred_taken_q;
    ent_pred_pc_d    = ent_pred_pc_q;
    redirect_valid_d = mispredict_c;
    flush_front_d    = mispredict_c;
    redirect_pc_d    = redirect_pc_q;
    branch_cnt_d     = branch_cnt_q;
    mispred_cnt_d    = mispred_cnt_q;

    // Wrong-path bubble wins over both hold and load
    if ((state_q == RECOVER) || mispredict_c) begin
      ent_valid_d = 1'b0;
    end else if (!stall_ex) begin
      ent_valid_d      = id_valid;
      ent_type_d       = id_type_c;
      ent_pc_d         = id_pc;
      ent_off_d        = id_offset;
      ent_pred_taken_d = id_pred_taken;
      ent_pred_pc_d    = id_pred_pc;
    end

    case (state_q)
      IDLE:    if (mispredict_c) state_d = RECOVER;
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (mispredict_c) redirect_pc_d = correct_pc_c;
    if (resolve_c && (branch_cnt_q != CNT_MAX)) branch_cnt_d = branch_cnt_q + XLEN'(1);
    if (mispredict_c && (mispred_cnt_q != CNT_MAX)) mispred_cnt_d = mispred_cnt_q + XLEN'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      ent_valid_q      <= 1'b0;
      ent_type_q       <= BR_NONE;
      ent_pc_q         <= '0;
      ent_off_q        <= '0;
      ent_pred_taken_q <= 1'b0;
      ent_pred_pc_q    <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_front_q    <= 1'b0;
      branch_cnt_q     <= '0;
      mispred_cnt_q    <= '0;
    end else begin
      state_q          <= state_d;
      ent_valid_q      <= ent_valid_d;
      ent_type_q       <= ent_type_d;
      ent_pc_q         <= ent_pc_d;
      ent_off_q        <= ent_off_d;
      ent_pred_taken_q <= ent_pred_taken_d;
      ent_pred_pc_q    <= ent_pred_pc_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_front_q    <= flush_front_d;
      branch_cnt_q     <= branch_cnt_d;
      mispred_cnt_q    <= mispred_cnt_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush_front    = flush_front_q;
  assign branch_cnt     = branch_cnt_q;
  assign mispred_cnt    = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with hand-computed expectations.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_branchBType, id_branchJAL, id_branchJALR;
  logic [31:0] id_pc, id_offset, id_pred_pc;
  logic        id_pred_taken;
  logic        stall_ex, ex_cond_true;
  logic [31:0] ex_rs1;
  logic        redirect_valid, flush_front;
  logic [31:0] redirect_pc, branch_cnt, mispred_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .id_branchBType (id_branchBType),
    .id_branchJAL   (id_branchJAL),
    .id_branchJALR  (id_branchJALR),
    .id_pc          (id_pc),
    .id_offset      (id_offset),
    .id_pred_taken  (id_pred_taken),
    .id_pred_pc     (id_pred_pc),
    .stall_ex       (stall_ex),
    .ex_cond_true   (ex_cond_true),
    .ex_rs1         (ex_rs1),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush_front    (flush_front),
    .branch_cnt     (branch_cnt),
    .mispred_cnt    (mispred_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic rv, input logic [31:0] rpc,
                           input logic fl, input logic [31:0] bc, input logic [31:0] mc);
    check({tag, ".rv"}, 32'(redirect_valid), 32'(rv));
    if (rv) check({tag, ".rpc"}, redirect_pc, rpc);
    check({tag, ".flush"}, 32'(flush_front), 32'(fl));
    check({tag, ".bcnt"}, branch_cnt, bc);
    check({tag, ".mcnt"}, mispred_cnt, mc);
  endtask

  task automatic drive_id(input logic v, input logic b, input logic j, input logic jr,
                          input logic [31:0] pc, input logic [31:0] off,
                          input logic pt, input logic [31:0] ppc);
    id_valid = v; id_branchBType = b; id_branchJAL = j; id_branchJALR = jr;
    id_pc = pc; id_offset = off; id_pred_taken = pt; id_pred_pc = ppc;
  endtask

  initial begin
    rst = 1'b1; stall_ex = 1'b0; ex_cond_true = 1'b0; ex_rs1 = '0;
    drive_id(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick(); tick();
    check("reset.rpc", redirect_pc, 32'h0);
    check_out("reset", 1'b0, 32'h0, 1'b0, 32'd0, 32'd0);
    rst = 1'b0;

    // B-type predicted taken, actually not taken
    drive_id(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'hFFFF_FFF0, 1'b1, 32'hF0);
    tick();
    drive_id(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    ex_cond_true = 1'b0;
    tick();
    check_out("b_mispred", 1'b1, 32'h104, 1'b1, 32'd1, 32'd1);
    tick();
    check_out("b_pulse_end", 1'b0, 32'h0, 1'b0, 32'd1, 32'd1);

    // JAL correctly predicted: no redirect
    drive_id(1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 32'h40, 1'b1, 32'h240);
    tick();
    drive_id(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    check_out("jal_ok", 1'b0, 32'h0, 1'b0, 32'd2, 32'd1);

    // JALR predicted not taken, target cleared to even
    drive_id(1'b1, 1'b0, 1'b0, 1'b1, 32'h300, 32'h4, 1'b0, 32'h0);
    tick();
    drive_id(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    ex_rs1 = 32'h1003;
    tick();
    check_out("jalr", 1'b1, 32'h1006, 1'b1, 32'd3, 32'd2);
    tick();
    check_out("jalr_end", 1'b0, 32'h0, 1'b0, 32'd3, 32'd2);

    // Stalled mispredicting B-type resolves once after release
    drive_id(1'b1, 1'b1, 1'b0, 1'b0, 32'h400, 32'h20, 1'b0, 32'h0);
    ex_cond_true = 1'b1;
    tick();
    drive_id(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    stall_ex = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("stall", 1'b0, 32'h0, 1'b0, 32'd3, 32'd2);
    end
    stall_ex = 1'b0;
    tick();
    check_out("stall_rel", 1'b1, 32'h420, 1'b1, 32'd4, 32'd3);
    tick();
    check_out("stall_end", 1'b0, 32'h0, 1'b0, 32'd4, 32'd3);
    tick();
    check_out("stall_once", 1'b0, 32'h0, 1'b0, 32'd4, 32'd3);

    // Back-to-back: second branch sits in ID across the mispredict and RECOVER
    drive_id(1'b1, 1'b1, 1'b0, 1'b0, 32'h500, 32'h8, 1'b0, 32'h0);
    ex_cond_true = 1'b1;
    tick();
    drive_id(1'b1, 1'b0, 1'b1, 1'b0, 32'h504, 32'h10, 1'b0, 32'h0);
    tick();
    check_out("b2b_first", 1'b1, 32'h508, 1'b1, 32'd5, 32'd4);
    tick();
    check_out("b2b_recover", 1'b0, 32'h0, 1'b0, 32'd5, 32'd4);
    drive_id(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    check_out("b2b_second", 1'b0, 32'h0, 1'b0, 32'd5, 32'd4);
    tick();
    check_out("b2b_quiet", 1'b0, 32'h0, 1'b0, 32'd5, 32'd4);

    // Reset in the resolving cycle abandons the redirect
    drive_id(1'b1, 1'b1, 1'b0, 1'b0, 32'h600, 32'h10, 1'b1, 32'h610);
    ex_cond_true = 1'b0;
    tick();
    drive_id(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    rst = 1'b1;
    tick();
    check_out("rst_mid", 1'b0, 32'h0, 1'b0, 32'd0, 32'd0);
    check("rst_mid.rpc", redirect_pc, 32'h0);
    rst = 1'b0;
    tick();
    check_out("rst_after", 1'b0, 32'h0, 1'b0, 32'd0, 32'd0);

    // Target add wraps modulo 2^32
    drive_id(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h8, 1'b0, 32'h0);
    ex_cond_true = 1'b1;
    tick();
    drive_id(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    check_out("wrap", 1'b1, 32'h4, 1'b1, 32'd1, 32'd1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
